shift_register_vd: RTL and testbench
====================================

# shift_register_vd

Variable-delay shift register that carries a valid bit with each word. It generalises the fixed-depth shift register:
- the delay (tap) is selected at runtime from 0 to DEPTH;
- the valid chain can be flushed synchronously;
- a `primed` status flags a fully filled chain;
- only the top RESETW data bits are reset.

It sits in MAC datapaths where a sideband or data stream must be aligned to a pipeline of configurable latency, such as FCS or timestamp alignment.

## Interface
- `DATAW`, 8, data word width (≥1).
- `RESETW`, 0, number of data MSBs cleared by reset, 0..DATAW. The remaining LSBs are not reset.
- `DEPTH`, 4, number of register stages (≥1).
- `SELW`, $clog2(DEPTH+1), width of `delay_sel`.
- `clk`  in  1  clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous reset, active-high.
- `enable`  in  1  shift advance; when low, all stages hold.
- `flush`  in  1  synchronous clear of all valid bits and the fill counter.
- `delay_sel`  in  SELW  selected delay in enabled cycles. 0 = combinational bypass; values > DEPTH are clamped to DEPTH.
- `valid_in`  in  1  qualifies `data_in`.
- `data_in`  in  DATAW  input word.
- `valid_out`  out  1  valid bit at the selected tap.
- `data_out`  out  DATAW  word at the selected tap.
- `primed`  out  1  high once DEPTH enabled shifts have occurred since reset or flush.

## Operation
- Storage is DEPTH stages s[0..DEPTH-1], each holding {v, d}.
- Shift on a rising edge with `enable`=1 and `flush`=0:
  - s[0] ← {`valid_in`, `data_in`};
  - s[k] ← s[k-1] for k ≥ 1.
- Tap select: let eff = min(`delay_sel`, DEPTH).
  - eff = 0: `data_out` = `data_in`, `valid_out` = `valid_in` (pure combinational path).
  - eff = N ≥ 1: outputs = s[N-1]. The mux is combinational from registered state and `delay_sel`.
- Flush (`flush`=1):
  - clears every s[k].v and the fill counter, regardless of `enable`;
  - `valid_in` in that cycle is discarded;
  - data fields hold and are not shifted.
- Fill counter:
  - 0..DEPTH, saturating;
  - increments on each enabled, non-flush edge;
  - `primed` = (count == DEPTH).
- Reset width:
  - d[DATAW-1 : DATAW-RESETW] of every stage is reset;
  - lower bits have no reset and may be mapped to SRL.
  - RESETW = 0: no data bit is reset. RESETW = DATAW: all data bits are reset.
- Changing `delay_sel` takes effect immediately on the outputs. Stage contents are not altered, so words may be skipped or repeated at the output. Upstream logic must flush if continuity matters.

## Timing
- Latency: a word presented with `enable`=1 at edge E appears at tap N after N enabled edges, i.e. at edge E+N-1 when `enable` is held high.
- `enable` low for M cycles adds M cycles of latency with no loss of data.
- Reset assertion (asynchronous, effective immediately, mid-operation included):
  - all v = 0, count = 0, reset data bits = 0;
  - therefore `valid_out` = 0 (when eff ≥ 1), `primed` = 0, and the top RESETW bits of `data_out` = 0;
  - non-reset bits are undefined.
- Reset deassertion: first shift at the first rising edge with `reset` low.
- `flush` and `enable` together: flush wins and no shift occurs.
- `flush` effect: `valid_out` is 0 in the cycle after the flush edge for any eff ≥ 1. `primed` drops at the same edge.
- Counter at DEPTH with further shifts: holds at DEPTH (no wrap).
- Boundary DEPTH = 1: SELW = 1, and only taps 0 and 1 exist.

## Test plan
- DATAW=8, DEPTH=4, `delay_sel`=3, `enable`=1, inputs 0x01,0x02,0x03… with valid=1 -> 0x01 with `valid_out`=1 on the output two cycles after being presented (edge E+2); `primed` rises after the 4th edge.
- `delay_sel`=0 -> `data_out` tracks `data_in` in the same cycle, including a `valid_in` toggle.
- Stream 0xA0..0xA7 while toggling `enable` as 1,0,0,1… with `delay_sel`=4 -> output sequence matches input order with no duplicates; latency grows by the number of stalled cycles.
- Fill all 4 stages with valid=1, then assert `flush` together with `enable`=1 and `valid_in`=1 -> `valid_out`=0 at every tap on the next cycle, `primed`=0, and that cycle's input is not captured.
- RESETW=4, DATAW=8: fill stages with 0xFF, then assert `reset` asynchronously mid-cycle -> `data_out`[7:4]=0x0 immediately, `valid_out`=0, `primed`=0; [3:0] is not checked.
- `delay_sel`=7 with DEPTH=4 -> behaviour identical to `delay_sel`=4.

Source files
------------

// File: rtl/shift_register_vd_if.sv
// Bus bundle for the variable-delay shift register: stream in, tap out,
// plus the shift/flush controls and fill status.
interface shift_register_vd_if #(
    parameter int DATAW = 8,
    parameter int DEPTH = 4,
    parameter int SELW  = $clog2(DEPTH + 1)
);
    logic             enable;
    logic             flush;
    logic [SELW-1:0]  delay_sel;
    logic             valid_in;
    logic [DATAW-1:0] data_in;
    logic             valid_out;
    logic [DATAW-1:0] data_out;
    logic             primed;

    // Upstream side: drives the stream and the controls.
    modport master (
        output enable, flush, delay_sel, valid_in, data_in,
        input  valid_out, data_out, primed
    );

    // Shift register side.
    modport slave (
        input  enable, flush, delay_sel, valid_in, data_in,
        output valid_out, data_out, primed
    );
endinterface

// File: rtl/shift_register_vd.sv
// Variable-delay shift register with a valid bit per word.
// Tap 0 is a combinational bypass, tap N reads stage N-1. Only the top
// RESETW data bits carry a reset so the remaining bits can map to SRLs.
module shift_register_vd #(
    parameter int DATAW  = 8,
    parameter int RESETW = 0,
    parameter int DEPTH  = 4,
    parameter int SELW   = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                reset,
    shift_register_vd_if.slave  bus
);

    localparam int CNTW = $clog2(DEPTH + 1);
    // Slice widths, forced to 1 when a region is empty so declarations
    // stay legal; the empty region's logic is never generated.
    localparam int HIW  = (RESETW > 0) ? RESETW : 1;
    localparam int LOW  = (RESETW < DATAW) ? (DATAW - RESETW) : 1;

    // Flush dominates enable: a flushing edge never shifts.
    logic shift_en;
    assign shift_en = bus.enable & ~bus.flush;

    logic [DEPTH-1:0] v_q, v_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;

    // Next state of the valid chain and the saturating fill counter.
    always_comb begin
        v_d   = v_q;
        cnt_d = cnt_q;
        if (bus.flush) begin
            v_d   = '0;
            cnt_d = '0;
        end else if (bus.enable) begin
            v_d[0] = bus.valid_in;
            for (int k = 1; k < DEPTH; k++) begin
                v_d[k] = v_q[k-1];
            end
            if (cnt_q != CNTW'(DEPTH)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Valid bits and fill counter always reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q   <= '0;
            cnt_q <= '0;
        end else begin
            v_q   <= v_d;
            cnt_q <= cnt_d;
        end
    end

    // Reassembled per-stage data word, fed from the two regions below.
    wire [DEPTH-1:0][DATAW-1:0] stg_data;

    generate
        if (RESETW > 0) begin : g_hi
            logic [DEPTH-1:0][HIW-1:0] hi_q, hi_d;

            // Shift of the reset-carrying MSB slice.
            always_comb begin
                hi_d = hi_q;
                if (shift_en) begin
                    hi_d[0] = bus.data_in[DATAW-1 -: HIW];
                    for (int k = 1; k < DEPTH; k++) begin
                        hi_d[k] = hi_q[k-1];
                    end
                end
            end

            // MSB slice registers with asynchronous clear.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    hi_q <= '0;
                end else begin
                    hi_q <= hi_d;
                end
            end

            for (genvar k = 0; k < DEPTH; k++) begin : g_hi_map
                assign stg_data[k][DATAW-1 -: HIW] = hi_q[k];
            end
        end

        if (RESETW < DATAW) begin : g_lo
            logic [DEPTH-1:0][LOW-1:0] lo_q, lo_d;

            // Shift of the LSB slice that has no reset.
            always_comb begin
                lo_d = lo_q;
                if (shift_en) begin
                    lo_d[0] = bus.data_in[LOW-1:0];
                    for (int k = 1; k < DEPTH; k++) begin
                        lo_d[k] = lo_q[k-1];
                    end
                end
            end

            // LSB slice registers, reset-free so they can become SRLs.
            always_ff @(posedge clk) begin
                lo_q <= lo_d;
            end

            for (genvar k = 0; k < DEPTH; k++) begin : g_lo_map
                assign stg_data[k][LOW-1:0] = lo_q[k];
            end
        end
    endgenerate

    logic [SELW-1:0]  sel_eff;
    logic             vout;
    logic [DATAW-1:0] dout;

    // Clamp the selected delay to the physical depth.
    always_comb begin
        sel_eff = bus.delay_sel;
        if (bus.delay_sel > SELW'(DEPTH)) begin
            sel_eff = SELW'(DEPTH);
        end
    end

    // Tap mux: tap 0 bypasses the chain, tap N reads stage N-1.
    always_comb begin
        vout = bus.valid_in;
        dout = bus.data_in;
        for (int k = 0; k < DEPTH; k++) begin
            if (sel_eff == SELW'(k + 1)) begin
                vout = v_q[k];
                dout = stg_data[k];
            end
        end
    end

    assign bus.valid_out = vout;
    assign bus.data_out  = dout;
    assign bus.primed    = (cnt_q == CNTW'(DEPTH));

endmodule

// File: tb/tb_shift_register_vd.sv
// Scoreboard bench for shift_register_vd (DATAW=8, RESETW=4, DEPTH=4).
module tb_shift_register_vd;
    localparam int DATAW  = 8;
    localparam int RESETW = 4;
    localparam int DEPTH  = 4;
    localparam int SELW   = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    shift_register_vd_if #(.DATAW(DATAW), .DEPTH(DEPTH), .SELW(SELW)) bus();

    shift_register_vd #(.DATAW(DATAW), .RESETW(RESETW), .DEPTH(DEPTH), .SELW(SELW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [7:0] d;
        int         due;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;
    int en_edges = 0;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic en, input logic fl, input logic vin, input logic [7:0] din);
        bus.enable   = en;
        bus.flush    = fl;
        bus.valid_in = vin;
        bus.data_in  = din;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        tick();
        sb.delete();
    endtask

    // One cycle of stream traffic; on enabled edges the tap is compared
    // against the scoreboard head (due) or must be invalid.
    task automatic shift_and_check(input logic en, input logic vin, input logic [7:0] din,
                                   input int n, input string tag);
        drive(en, 1'b0, vin, din);
        tick();
        if (en) begin
            en_edges++;
            if (vin) sb.push_back('{din, en_edges + n - 1});
            total++;
            if (sb.size() > 0 && sb[0].due == en_edges) begin
                if (bus.valid_out !== 1'b1 || bus.data_out !== sb[0].d) begin
                    bad++;
                    $display("FAIL %s: got valid=%b data=%h, want valid=1 data=%h",
                             tag, bus.valid_out, bus.data_out, sb[0].d);
                end
                sb.delete(0);
            end else if (bus.valid_out !== 1'b0) begin
                bad++;
                $display("FAIL %s: got valid=%b data=%h, want valid=0",
                         tag, bus.valid_out, bus.data_out);
            end
        end
    endtask

    task automatic drain(input int n, input string tag);
        for (int i = 0; i < 20 && sb.size() > 0; i++) begin
            shift_and_check(1'b1, 1'b0, 8'h00, n, tag);
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: %0d words never appeared, want 0", tag, sb.size());
            sb.delete();
        end
    endtask

    task automatic check_tap(input int sel, input logic ev, input logic [7:0] ed, input string tag);
        bus.delay_sel = SELW'(sel);
        #1;
        total++;
        if (bus.valid_out !== ev || bus.data_out !== ed) begin
            bad++;
            $display("FAIL %s sel=%0d: got valid=%b data=%h, want valid=%b data=%h",
                     tag, sel, bus.valid_out, bus.data_out, ev, ed);
        end
    endtask

    task automatic check_primed(input logic ep, input string tag);
        total++;
        if (bus.primed !== ep) begin
            bad++;
            $display("FAIL %s: got primed=%b, want %b", tag, bus.primed, ep);
        end
    endtask

    task automatic check_rst_taps(input string tag);
        for (int s = 1; s <= DEPTH; s++) begin
            bus.delay_sel = SELW'(s);
            #1;
            total++;
            if (bus.valid_out !== 1'b0 || bus.data_out[7:4] !== 4'h0) begin
                bad++;
                $display("FAIL %s sel=%0d: got valid=%b msb=%h, want valid=0 msb=0",
                         tag, s, bus.valid_out, bus.data_out[7:4]);
            end
        end
        check_primed(1'b0, {tag, "_primed"});
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        bus.delay_sel = '0;
        repeat (2) @(posedge clk);
        #2;
        check_rst_taps("reset");
        @(negedge clk);
        reset = 1'b0;
        tick();
    endtask

    task automatic test_delay3();
        do_flush();
        bus.delay_sel = 3'd3;
        for (int i = 1; i <= 8; i++) begin
            shift_and_check(1'b1, 1'b1, 8'(i), 3, "delay3");
            check_primed(i >= DEPTH, "delay3_primed");
        end
        drain(3, "delay3");
    endtask

    task automatic test_bypass();
        logic       v;
        logic [7:0] d;
        bus.delay_sel = 3'd0;
        for (int i = 0; i < 6; i++) begin
            v = (i % 2 == 0);
            d = 8'h30 + 8'(i * 7);
            drive(1'b1, 1'b0, v, d);
            #1;
            total++;
            if (bus.valid_out !== v || bus.data_out !== d) begin
                bad++;
                $display("FAIL bypass: got valid=%b data=%h, want valid=%b data=%h",
                         bus.valid_out, bus.data_out, v, d);
            end
            tick();
        end
    endtask

    task automatic test_stall();
        int w;
        logic en;
        do_flush();
        bus.delay_sel = 3'd4;
        w = 0;
        for (int j = 0; w < 8; j++) begin
            en = (j % 3 == 0);
            shift_and_check(en, 1'b1, en ? (8'hA0 + 8'(w)) : 8'hEE, 4, "stall");
            if (en) w++;
        end
        drain(4, "stall");
    endtask

    task automatic test_flush();
        do_flush();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 1'b0, 1'b1, 8'hC0 + 8'(i));
            tick();
        end
        check_primed(1'b1, "flush_pre_primed");
        drive(1'b1, 1'b1, 1'b1, 8'h55);
        tick();
        check_primed(1'b0, "flush_primed");
        check_tap(1, 1'b0, 8'hC3, "flush");
        check_tap(2, 1'b0, 8'hC2, "flush");
        check_tap(3, 1'b0, 8'hC1, "flush");
        check_tap(4, 1'b0, 8'hC0, "flush");
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        tick();
        check_tap(2, 1'b0, 8'hC3, "flush_after");
    endtask

    task automatic test_clamp();
        do_flush();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 1'b0, 1'b1, 8'hD0 + 8'(i));
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        check_tap(3, 1'b1, 8'hD1, "clamp");
        for (int s = 4; s <= 7; s++) begin
            check_tap(s, 1'b1, 8'hD0, "clamp");
        end
    endtask

    task automatic test_async_reset();
        do_flush();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 1'b0, 1'b1, 8'hFF);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        check_tap(2, 1'b1, 8'hFF, "arst_pre");
        @(posedge clk);
        #3;
        reset = 1'b1;
        check_rst_taps("arst");
        @(negedge clk);
        reset = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_delay3();
        test_bypass();
        test_stall();
        test_flush();
        test_clamp();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
